// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: a 16 x 8 FIFO feeding an 8-bit serial framer
// with optional even/odd parity. Frames are start, 8 data bits LSB first,
// optional parity, one stop bit; each bit lasts BIT_CYCLES clk cycles.
// Write side: wr_en is a single-cycle strobe; a write is taken on any rising
// edge where wr_en=1 and full=0, otherwise it is dropped and overflow sticks.
// The FSM state is kept in the `state` signal for observation.
module uart_tx_buf #(
  parameter int BIT_CYCLES = 16,
  parameter int PARITY     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic [4:0] level,
  output logic       busy,
  output logic       overflow,
  output logic       tx
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  // PARITY=3 (or any other value) falls back to no parity.
  localparam logic        PAR_EN   = (PARITY == 1) || (PARITY == 2);
  localparam logic        PAR_ODD  = (PARITY == 2);
  localparam logic [15:0] LAST_CNT = 16'(BIT_CYCLES - 1);

  state_t      state, state_n;
  logic [7:0]  mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [15:0] bit_cnt, bit_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;
  logic        pop;
  logic        push;
  logic        bit_done;
  logic [4:0]  level_n;

  assign push     = wr_en && !full;
  assign bit_done = (bit_cnt == LAST_CNT);
  assign level_n  = level + 5'(push) - 5'(pop);
  assign busy     = (state != IDLE) || !empty;

  // FIFO storage; no reset needed, occupancy is tracked by level.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers, registered occupancy flags and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 4'd1;
      if (pop)  rd_ptr <= rd_ptr + 4'd1;
      level    <= level_n;
      full     <= (level_n == 5'd16);
      empty    <= (level_n == 5'd0);
      overflow <= overflow | (wr_en & full);
    end
  end

  // Framer state register and serial datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      tx      <= tx_n;
    end
  end

  // Next-state, next tx value and FIFO pop decision.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shreg_n   = mem[rd_ptr];
          tx_n      = 1'b0;
          bit_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          bit_idx_n = '0;
          tx_n      = shreg[0];
          state_n   = DATA;
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            if (PAR_EN) begin
              tx_n    = (^shreg) ^ PAR_ODD;
              state_n = PAR;
            end else begin
              tx_n    = 1'b1;
              state_n = STOP;
            end
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            tx_n      = shreg[bit_idx + 3'd1];
          end
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      PAR: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          tx_n      = 1'b1;
          state_n   = STOP;
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          bit_cnt_n = '0;
          if (!empty) begin
            // Back-to-back frame: next start bit follows the stop bit directly.
            pop     = 1'b1;
            shreg_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt + 16'd1;
        end
      end
      default: begin
        tx_n    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf with BIT_CYCLES=4. Four instances share all inputs:
// PARITY 0 (main), 1 (even), 2 (odd), 3 (treated as none).
module tb_uart_tx_buf;

  localparam int BC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;

  logic       full0, empty0, busy0, ovf0, tx0;
  logic [4:0] level0;
  logic       full1, empty1, busy1, ovf1, tx1;
  logic [4:0] level1;
  logic       full2, empty2, busy2, ovf2, tx2;
  logic [4:0] level2;
  logic       full3, empty3, busy3, ovf3, tx3;
  logic [4:0] level3;

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];
  bit rx_done;

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       push;
    logic [4:0] level;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vt[18];

  uart_tx_buf #(.BIT_CYCLES(BC), .PARITY(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full0),
    .empty(empty0), .level(level0), .busy(busy0), .overflow(ovf0), .tx(tx0));
  uart_tx_buf #(.BIT_CYCLES(BC), .PARITY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full1),
    .empty(empty1), .level(level1), .busy(busy1), .overflow(ovf1), .tx(tx1));
  uart_tx_buf #(.BIT_CYCLES(BC), .PARITY(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full2),
    .empty(empty2), .level(level2), .busy(busy2), .overflow(ovf2), .tx(tx2));
  uart_tx_buf #(.BIT_CYCLES(BC), .PARITY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .full(full3),
    .empty(empty3), .level(level3), .busy(busy3), .overflow(ovf3), .tx(tx3));

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_tx(input int sel);
    case (sel)
      0: return tx0;
      1: return tx1;
      2: return tx2;
      default: return tx3;
    endcase
  endfunction

  // Driver: one write strobe on the next rising edge; queues the byte as expected.
  task automatic write_byte(input logic [7:0] b);
    wr_data = b;
    wr_en = 1'b1;
    exp_q.push_back(b);
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic wait_fall(input int sel, input string name);
    int n = 0;
    while (get_tx(sel) !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check({name, " start seen"}, get_tx(sel), 1'b0);
  endtask

  // Cycle-exact frame check, starting on the first start-bit sample.
  task automatic expect_frame(input int sel, input logic [7:0] b, input int par,
                              input string name, input bit last);
    logic bits[11];
    int nb;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = b[i];
    nb = 9;
    if (par == 1 || par == 2) begin
      bits[9] = (^b) ^ (par == 2);
      nb = 10;
    end
    bits[nb] = 1'b1;
    nb++;
    for (int j = 0; j < nb; j++) begin
      for (int c = 0; c < BC; c++) begin
        check($sformatf("%s bit%0d cyc%0d", name, j, c), get_tx(sel), bits[j]);
        if (last && j == nb - 1 && c == BC - 1) check({name, " busy in last cycle"}, busy0, 1'b1);
        step();
      end
    end
    if (last) check({name, " busy after frame"}, busy0, 1'b0);
  endtask

  // Scoreboard receiver on the main instance: decodes one frame mid-bit.
  task automatic recv_check(input string name);
    logic [7:0] b;
    int n = 0;
    while (tx0 !== 1'b0 && n < 400) begin
      step();
      n++;
    end
    check({name, " start seen"}, tx0, 1'b0);
    if (n < 400) begin
      repeat (2) step();
      check({name, " start mid"}, tx0, 1'b0);
      for (int i = 0; i < 8; i++) begin
        repeat (4) step();
        b[i] = tx0;
      end
      repeat (4) step();
      check({name, " stop"}, tx0, 1'b1);
      repeat (2) step();
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL %s: got byte %02h expected none", name, b);
      end else begin
        check({name, " byte"}, b, exp_q.pop_front());
      end
    end
  endtask

  task automatic rx_wait(input string name);
    int n = 0;
    while (!rx_done && n < 2000) begin
      step();
      n++;
    end
    check({name, " receiver finished"}, rx_done, 1'b1);
  endtask

  initial begin
    // Vectors for the overflow run: 16 writes fill the FIFO while a frame is
    // in flight, the 17th is dropped, then one idle cycle.
    vt[0]  = '{1'b1, 8'h10, 1'b1, 5'd1,  1'b0, 1'b0};
    vt[1]  = '{1'b1, 8'h21, 1'b1, 5'd2,  1'b0, 1'b0};
    vt[2]  = '{1'b1, 8'h32, 1'b1, 5'd3,  1'b0, 1'b0};
    vt[3]  = '{1'b1, 8'h43, 1'b1, 5'd4,  1'b0, 1'b0};
    vt[4]  = '{1'b1, 8'h54, 1'b1, 5'd5,  1'b0, 1'b0};
    vt[5]  = '{1'b1, 8'h65, 1'b1, 5'd6,  1'b0, 1'b0};
    vt[6]  = '{1'b1, 8'h76, 1'b1, 5'd7,  1'b0, 1'b0};
    vt[7]  = '{1'b1, 8'h87, 1'b1, 5'd8,  1'b0, 1'b0};
    vt[8]  = '{1'b1, 8'h98, 1'b1, 5'd9,  1'b0, 1'b0};
    vt[9]  = '{1'b1, 8'hA9, 1'b1, 5'd10, 1'b0, 1'b0};
    vt[10] = '{1'b1, 8'hBA, 1'b1, 5'd11, 1'b0, 1'b0};
    vt[11] = '{1'b1, 8'hCB, 1'b1, 5'd12, 1'b0, 1'b0};
    vt[12] = '{1'b1, 8'hDC, 1'b1, 5'd13, 1'b0, 1'b0};
    vt[13] = '{1'b1, 8'hED, 1'b1, 5'd14, 1'b0, 1'b0};
    vt[14] = '{1'b1, 8'hFE, 1'b1, 5'd15, 1'b0, 1'b0};
    vt[15] = '{1'b1, 8'h0F, 1'b1, 5'd16, 1'b1, 1'b0};
    vt[16] = '{1'b1, 8'hEE, 1'b0, 5'd16, 1'b1, 1'b1};
    vt[17] = '{1'b0, 8'h00, 1'b0, 5'd16, 1'b1, 1'b1};

    // Reset values
    repeat (3) step();
    check("rst tx", tx0, 1'b1);
    check("rst level", level0, 5'd0);
    check("rst empty", empty0, 1'b1);
    check("rst full", full0, 1'b0);
    check("rst busy", busy0, 1'b0);
    check("rst overflow", ovf0, 1'b0);
    rst_n = 1'b1;

    // Single 0x55 frame: tx falls on the edge after the one that takes the write
    do_reset();
    write_byte(8'h55);
    check("lat tx high at write edge", tx0, 1'b1);
    check("lat level after write", level0, 5'd1);
    step();
    check("lat level after pop", level0, 5'd0);
    expect_frame(0, exp_q.pop_front(), 0, "f55", 1'b1);
    check("f55 tx idle", tx0, 1'b1);

    // 0x07 with each parity setting
    do_reset();
    write_byte(8'h07);
    step();
    fork
      expect_frame(0, 8'h07, 0, "p0", 1'b1);
      expect_frame(1, 8'h07, 1, "p_even", 1'b0);
      expect_frame(2, 8'h07, 2, "p_odd", 1'b0);
      expect_frame(3, 8'h07, 0, "p_illegal", 1'b0);
    join
    check("p_even busy end", busy1, 1'b0);
    check("p_odd busy end", busy2, 1'b0);
    check("p_illegal busy end", busy3, 1'b0);

    // Three consecutive writes: contiguous frames in order
    do_reset();
    fork
      begin
        write_byte(8'h01);
        write_byte(8'h80);
        write_byte(8'hFF);
      end
    join_none
    wait_fall(0, "b2b");
    expect_frame(0, exp_q.pop_front(), 0, "b2b f0", 1'b0);
    expect_frame(0, exp_q.pop_front(), 0, "b2b f1", 1'b0);
    expect_frame(0, exp_q.pop_front(), 0, "b2b f2", 1'b1);

    // Overflow: 17 writes while a frame is in flight
    do_reset();
    write_byte(8'hC3);
    rx_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 17; k++) recv_check($sformatf("ovf rx%0d", k));
        rx_done = 1'b1;
      end
    join_none
    step();
    check("ovf in frame", tx0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      wr_en = vt[i].wr;
      wr_data = vt[i].data;
      if (vt[i].push) exp_q.push_back(vt[i].data);
      step();
      wr_en = 1'b0;
      check($sformatf("ovf v%0d level", i), level0, vt[i].level);
      check($sformatf("ovf v%0d full", i), full0, vt[i].full);
      check($sformatf("ovf v%0d empty", i), empty0, 1'b0);
      check($sformatf("ovf v%0d busy", i), busy0, 1'b1);
      check($sformatf("ovf v%0d overflow", i), ovf0, vt[i].ovf);
    end
    rx_wait("ovf");
    check("ovf drained level", level0, 5'd0);
    check("ovf drained empty", empty0, 1'b1);
    check("ovf sticky", ovf0, 1'b1);

    // Write while full on the pop edge, then write+pop at level 15
    do_reset();
    check("wp overflow cleared", ovf0, 1'b0);
    write_byte(8'h3C);
    rx_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 18; k++) recv_check($sformatf("wp rx%0d", k));
        rx_done = 1'b1;
      end
    join_none
    for (int k = 0; k < 16; k++) write_byte(8'(8'h61 + k * 7));
    check("wp full level", level0, 5'd16);
    check("wp full flag", full0, 1'b1);
    repeat (24) step();
    check("wp before pop level", level0, 5'd16);
    check("wp before pop overflow", ovf0, 1'b0);
    wr_data = 8'hEE;
    wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("wp drop overflow", ovf0, 1'b1);
    check("wp drop level", level0, 5'd15);
    check("wp drop full", full0, 1'b0);
    repeat (39) step();
    check("wp before 2nd pop level", level0, 5'd15);
    write_byte(8'h5A);
    check("wp write+pop level", level0, 5'd15);
    rx_wait("wp");
    check("wp drained level", level0, 5'd0);

    // Asynchronous reset during data bit 3 with 5 bytes queued
    do_reset();
    write_byte(8'hF7);
    for (int k = 0; k < 5; k++) write_byte(8'(8'h11 * (k + 1)));
    check("ar queued level", level0, 5'd5);
    repeat (13) step();
    check("ar bit3 before reset", tx0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("ar tx", tx0, 1'b1);
    check("ar level", level0, 5'd0);
    check("ar empty", empty0, 1'b1);
    check("ar full", full0, 1'b0);
    check("ar busy", busy0, 1'b0);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    wr_data = 8'hA5;
    wr_en = 1'b1;
    exp_q.push_back(8'hA5);
    step();
    wr_en = 1'b0;
    check("ar first write level", level0, 5'd1);
    check("ar first write tx", tx0, 1'b1);
    step();
    expect_frame(0, exp_q.pop_front(), 0, "ar fA5", 1'b1);
    check("ar final level", level0, 5'd0);
    check("ar final tx", tx0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
